// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: counter encoding, FSM states, index hash.
package bp_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_e;

    // PC word address XOR zero-extended history; the caller truncates to its
    // own index width, so any table size can share this one definition.
    function automatic logic [31:0] bp_index(input logic [63:0] pc,
                                             input logic [31:0] hist);
        return 32'((pc >> 2) ^ {32'b0, hist});
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter step (combinational).
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_next_o
);

    // Move one step toward the resolved direction, sticking at the ends.
    always_comb begin
        ctr_next_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_ST) ctr_next_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != CTR_SNT) ctr_next_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/pht.sv
// Pattern history table: hashed 2-bit counters, registered prediction,
// two-stage read-modify-write update with forwarding, init sweep after reset.
module pht
    import bp_pkg::*;
#(
    parameter int LINE_NUM   = 1024,
    parameter int HIST_WIDTH = 6,
    parameter int PC_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  req_valid,
    input  logic [PC_WIDTH-1:0]   req_pc,
    input  logic [HIST_WIDTH-1:0] req_hist,
    output logic                  pred_valid,
    output logic                  pred_taken,
    output logic [1:0]            pred_ctr,
    input  logic                  upd_valid,
    input  logic [PC_WIDTH-1:0]   upd_pc,
    input  logic [HIST_WIDTH-1:0] upd_hist,
    input  logic                  upd_taken,
    output logic                  busy
);

    localparam int IDX_W = $clog2(LINE_NUM);

    bp_state_e        state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic             run;

    logic [1:0]       ctr_q [LINE_NUM];

    logic [IDX_W-1:0] req_idx, upd_idx;
    logic [1:0]       req_rd, upd_rd;

    // U1 holds a captured update; U2 is the combinational saturate + write.
    logic             u1_vld_q, u1_vld_d;
    logic [IDX_W-1:0] u1_idx_q;
    logic             u1_taken_q;
    logic [1:0]       u1_ctr_q;
    logic [1:0]       u2_new;

    logic             pred_valid_q;
    logic [1:0]       pred_ctr_q;

    assign req_idx = IDX_W'(bp_index(64'(req_pc), 32'(req_hist)));
    assign upd_idx = IDX_W'(bp_index(64'(upd_pc), 32'(upd_hist)));
    assign run     = (state_q == RUN);

    sat_counter2 u_sat (
        .ctr_i      (u1_ctr_q),
        .taken_i    (u1_taken_q),
        .ctr_next_o (u2_new)
    );

    // Next state: sweep every entry once, then run until the next reset.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        busy    = 1'b0;
        case (state_q)
            INIT: begin
                busy    = 1'b1;
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == IDX_W'(LINE_NUM - 1)) state_d = RUN;
            end
            default: ;
        endcase
    end

    // FSM and sweep pointer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Reads see the in-flight U2 write so same-index traffic never goes stale.
    always_comb begin
        req_rd   = (u1_vld_q && (u1_idx_q == req_idx)) ? u2_new : ctr_q[req_idx];
        upd_rd   = (u1_vld_q && (u1_idx_q == upd_idx)) ? u2_new : ctr_q[upd_idx];
        u1_vld_d = upd_valid && !stall && run;
    end

    // U1 capture; a stall only blocks new captures, never the pending write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            u1_vld_q <= 1'b0;
        end else begin
            u1_vld_q <= u1_vld_d;
            if (u1_vld_d) begin
                u1_idx_q   <= upd_idx;
                u1_taken_q <= upd_taken;
                u1_ctr_q   <= upd_rd;
            end
        end
    end

    // Counter array: sweep writes in INIT, U2 writes in RUN, nothing in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == INIT)  ctr_q[sweep_q]  <= CTR_WNT;
            else if (u1_vld_q)    ctr_q[u1_idx_q] <= u2_new;
        end
    end

    // Prediction registers; frozen by stall and idle during INIT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pred_valid_q <= 1'b0;
            pred_ctr_q   <= CTR_SNT;
        end else if (run && !stall) begin
            pred_valid_q <= req_valid;
            pred_ctr_q   <= req_rd;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_ctr   = pred_ctr_q;
    assign pred_taken = pred_ctr_q[1];

endmodule

// File: tb/tb_pht.sv
// Scoreboard bench for pht: stimulus pushes expected counters, monitor pops.
module tb_pht;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_pc = '0;
    logic [5:0]  req_hist = '0;
    logic        pred_valid, pred_taken;
    logic [1:0]  pred_ctr;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [5:0]  upd_hist = '0;
    logic        upd_taken = 1'b0;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [1:0] expq [$];

    pht #(.LINE_NUM(1024), .HIST_WIDTH(6), .PC_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .req_valid(req_valid), .req_pc(req_pc), .req_hist(req_hist),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ctr(pred_ctr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(upd_hist),
        .upd_taken(upd_taken), .busy(busy)
    );

    always #5 clk = ~clk;

    // Monitor: every valid prediction must match the next queued expectation.
    always @(negedge clk) begin
        if (pred_valid) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pred: got pred_valid=1 ctr=%0d, required no prediction", pred_ctr);
            end else begin
                logic [1:0] e;
                e = expq.pop_front();
                if (pred_ctr !== e || pred_taken !== e[1]) begin
                    bad++;
                    $display("FAIL pred: got ctr=%0d taken=%0b, required ctr=%0d taken=%0b",
                             pred_ctr, pred_taken, e, e[1]);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // One cycle of inputs; exp >= 0 queues the prediction expected after it.
    task automatic step(input logic rv, input logic [31:0] pc, input logic [5:0] h,
                        input logic uv, input logic [31:0] upc, input logic [5:0] uh,
                        input logic ut, input logic st, input int exp);
        req_valid = rv; req_pc = pc; req_hist = h;
        upd_valid = uv; upd_pc = upc; upd_hist = uh; upd_taken = ut;
        stall = st;
        if (exp >= 0) expq.push_back(exp[1:0]);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, -1);
    endtask

    task automatic look(input logic [31:0] pc, input logic [5:0] h, input int exp);
        step(1'b1, pc, h, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0, exp);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [5:0] h, input logic t);
        step(1'b0, 32'h0, 6'h0, 1'b1, pc, h, t, 1'b0, -1);
    endtask

    // Release reset and count edges until busy drops, with lookups applied.
    task automatic sweep_wait(input string name);
        int n;
        n = 0;
        rst = 1'b1;
        req_valid = 1'b1; req_pc = 32'h40; req_hist = '0;
        upd_valid = 1'b1; upd_pc = 32'h40; upd_hist = '0; upd_taken = 1'b1;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy && n < 2000);
        check(name, n, 1024);
        req_valid = 1'b0; upd_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_pred_valid", pred_valid, 0);
        check("reset_pred_ctr", pred_ctr, 0);
        check("reset_pred_taken", pred_taken, 0);
        check("reset_busy", busy, 1);

        sweep_wait("init_cycles");
        check("run_busy", busy, 0);

        // Freshly initialised entries, including a hist-hashed index.
        look(32'h40, 6'h0, 1);
        look(32'h1000, 6'h5, 1);
        idle();

        // Saturate up at idx 0x10, then floor at 00.
        upd(32'h40, 6'h0, 1'b1); idle(); look(32'h40, 6'h0, 2);
        upd(32'h40, 6'h0, 1'b1); idle(); look(32'h40, 6'h0, 3);
        upd(32'h40, 6'h0, 1'b1); idle(); look(32'h40, 6'h0, 3);
        upd(32'h40, 6'h0, 1'b0); idle(); look(32'h40, 6'h0, 2);
        upd(32'h40, 6'h0, 1'b0); idle(); look(32'h40, 6'h0, 1);
        upd(32'h40, 6'h0, 1'b0); idle(); look(32'h40, 6'h0, 0);
        upd(32'h40, 6'h0, 1'b0); idle(); look(32'h40, 6'h0, 0);

        // Back-to-back taken updates to idx 0x20 accumulate via forwarding.
        upd(32'h80, 6'h0, 1'b1); upd(32'h80, 6'h0, 1'b1); idle();
        look(32'h80, 6'h0, 3);

        // Lookup in the cycle U2 writes idx 0x30 sees the new value.
        upd(32'hC0, 6'h0, 1'b1);
        look(32'hC0, 6'h0, 2);
        idle();

        // Hash: pc 0x100 hist 3 and pc 0x10C hist 0 share idx 0x43.
        upd(32'h100, 6'h3, 1'b1); idle();
        look(32'h10C, 6'h0, 2);
        idle();

        // Stall: outputs hold, new update blocked, in-flight U2 lands.
        step(1'b1, 32'h40, 6'h0, 1'b1, 32'hC0, 6'h0, 1'b1, 1'b0, 0);
        repeat (3) step(1'b1, 32'h80, 6'h0, 1'b1, 32'h40, 6'h0, 1'b1, 1'b1, 0);
        idle();
        look(32'hC0, 6'h0, 3);
        look(32'h40, 6'h0, 0);
        idle();

        // Reset with an update sitting in U1.
        upd(32'h80, 6'h0, 1'b0);
        rst = 1'b0; upd_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst_pred_valid", pred_valid, 0);
        check("midrst_busy", busy, 1);
        sweep_wait("reinit_cycles");
        look(32'h80, 6'h0, 1);
        look(32'h40, 6'h0, 1);
        look(32'hC0, 6'h0, 1);
        look(32'h10C, 6'h0, 1);
        idle();
        idle();

        check("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pht.md
# pht

Pattern history table stage directly downstream of the per-branch local-history table in the IFU branch predictor. It hashes the fetch PC with the local history produced by the history table into an index over an array of 2-bit saturating counters. It returns a registered taken/not-taken prediction and applies resolved-branch updates through a two-stage read-modify-write pipeline with forwarding. After every reset it clears itself with an init sweep.

## Interface

Parameters:

- LINE_NUM, 1024, counter entries; power of two; IDX_W = $clog2(LINE_NUM)
- HIST_WIDTH, 6, local-history width; must satisfy HIST_WIDTH <= IDX_W
- PC_WIDTH, 32, PC width; must satisfy PC_WIDTH >= IDX_W+2

Ports:

- clk, in, 1, clock; all state updates on rising edge
- rst, in, 1, one clock; reset is synchronous and active-low
- stall, in, 1, pipeline freeze; holds prediction outputs and blocks update capture
- req_valid, in, 1, lookup request
- req_pc, in, PC_WIDTH, fetch PC
- req_hist, in, HIST_WIDTH, local history for req_pc from the history table
- pred_valid, out, 1, prediction valid
- pred_taken, out, 1, predicted direction
- pred_ctr, out, 2, counter value used for the prediction
- upd_valid, in, 1, resolved-branch update
- upd_pc, in, PC_WIDTH, PC of the resolved branch
- upd_hist, in, HIST_WIDTH, history as it was before the outcome shifted in
- upd_taken, in, 1, resolved direction
- busy, out, 1, init sweep in progress

## Operation

- Index: idx = req_pc[IDX_W+1:2] XOR zero-extended hist. The same function applies on the update path with upd_pc and upd_hist.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Prediction rule: pred_taken = ctr[1].
- Saturation on update:
  - taken: ctr+1, capped at 11
  - not-taken: ctr-1, floored at 00
  - arithmetic is 2-bit and never wraps
- FSM states:
  - INIT: entered on any cycle with rst=0. Sweep counter starts at 0 and writes 01 to entry sweep each cycle. Leaves to RUN after writing entry LINE_NUM-1.
  - RUN: normal operation; no exit except reset.
- In INIT:
  - busy=1
  - pred_valid=0
  - upd_valid and req_valid are ignored; updates are dropped
- Lookup, RUN only, when stall=0:
  - prediction registers load from the array at idx
  - pred_valid <= req_valid
  - when stall=1, all pred_* outputs hold
- Update pipeline, RUN only:
  - U1 captures {idx, upd_taken} and reads the counter when upd_valid & ~stall.
  - U2 writes the saturated value on the next edge. U2 always completes, even if stall asserts.
- Forwarding:
  - If U1 reads the index that U2 is writing in the same cycle, U1 uses U2's new value. Back-to-back updates to one index accumulate.
  - If a lookup reads the index U2 is writing in the same cycle, the lookup returns the new value.
- Reset mid-operation: a pending U1/U2 update is discarded, the sweep restarts at 0, and pred_valid clears.

## Timing

- Reset values: pred_valid=0, pred_taken=0, pred_ctr=00, busy=1, state=INIT, sweep=0, U1/U2 valid=0.
- Init duration: busy stays 1 for exactly LINE_NUM rising edges after the first edge sampling rst=1. busy=0 from the following cycle.
- Lookup latency: 1 cycle. req sampled at edge N appears on pred_* after edge N.
- Update latency: upd sampled at edge N is written at edge N+1. A lookup sampled at edge N+1 sees it via bypass; a lookup at N+2 or later reads it from the array.
- Throughput: one lookup and one update per cycle, concurrently.

## Structure

- Shared package bp_pkg holds:
  - counter encoding constants CTR_SNT/CTR_WNT/CTR_WT/CTR_ST
  - FSM state typedef {INIT, RUN}
  - the index-hash function, so the history table side and this stage agree
- Sub-module sat_counter2: combinational 2-bit saturating increment/decrement (ctr, taken -> ctr_next). Instantiated once in U2.
- Counter array is a register array with asynchronous read. Top-level RTL target is about 200 lines.

## Test plan

- Reset, then idle. busy=1 for 1024 cycles then 0; every lookup returns pred_ctr=01, pred_taken=0; pred_valid=0 throughout INIT.
- In RUN, three taken updates at pc=0x40, hist=0. Lookup at pc=0x40, hist=0 then gives pred_ctr 10→11→11 (saturated), pred_taken=1. Four not-taken updates then floor the counter at 00.
- Back-to-back updates to the same index on consecutive cycles with taken,taken from 01. Final counter=11, which proves U2→U1 forwarding.
- Lookup sampled on the cycle U2 writes the same index 01→10 returns pred_ctr=10, pred_taken=1.
- stall=1 for 3 cycles with req_valid and upd_valid high and different values. pred_* hold their prior values and no update is captured; an update already in U2 still lands.
- rst=0 pulsed mid-RUN with an update in U1. After reset the sweep restarts, all entries read 01, and the dropped update never appears.
